// File: rtl/io_step_if.sv
// Board/core signal bundle for io_step_controller.
// The optional step_sw line exists only when SINGLE_STEP_EN is defined.
interface io_step_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  botao;
    logic                  congela_sw;
    logic [7:0]            switches;
    logic                  is_in;
    logic                  is_out;
    logic                  halt;
    logic [DATA_WIDTH-1:0] out_value;
`ifdef SINGLE_STEP_EN
    logic                  step_sw;
`endif
    logic                  step_en;
    logic                  congela_in;
    logic                  congela_out;
    logic                  halted;
    logic [7:0]            in_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  led_pc;
    logic [2:0]            state;

`ifdef SINGLE_STEP_EN
    modport master (
        output botao, congela_sw, switches, is_in, is_out, halt, out_value, step_sw,
        input  step_en, congela_in, congela_out, halted, in_data, out_data, led_pc, state
    );
    modport slave (
        input  botao, congela_sw, switches, is_in, is_out, halt, out_value, step_sw,
        output step_en, congela_in, congela_out, halted, in_data, out_data, led_pc, state
    );
`else
    modport master (
        output botao, congela_sw, switches, is_in, is_out, halt, out_value,
        input  step_en, congela_in, congela_out, halted, in_data, out_data, led_pc, state
    );
    modport slave (
        input  botao, congela_sw, switches, is_in, is_out, halt, out_value,
        output step_en, congela_in, congela_out, halted, in_data, out_data, led_pc, state
    );
`endif
endinterface

// File: rtl/io_step_controller.sv
// Run-control sequencer for the single-cycle MIPS core: step enable, IN/OUT holds and HALT park.
// Optional manual single-step mode enabled by defining SINGLE_STEP_EN.
module io_step_controller #(
    parameter int unsigned DIV_COUNT  = 50000000,
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic        clock_fpga,
    input logic        reset_n,
    io_step_if.slave   io
);

    localparam int unsigned DivW = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
    localparam int unsigned DebW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(DIV_COUNT - 1);
    localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        StRun     = 3'd0,
        StWaitIn  = 3'd1,
        StWaitOut = 3'd2,
        StRelease = 3'd3,
        StHalted  = 3'd4
    } state_e;

    logic                  sync1_q, sync2_q;
    logic [DebW-1:0]       deb_cnt_q, deb_cnt_d;
    logic                  deb_level_q, deb_level_d;
    logic                  press;
    state_e                state_q, state_d;
    logic [DivW-1:0]       div_q, div_d;
    logic                  step_q, step_d;
    logic                  led_q, led_d;
    logic                  cin_q, cin_d;
    logic                  cout_q, cout_d;
    logic                  halted_q, halted_d;
    logic [7:0]            in_data_q, in_data_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    // Debounced level is 1 when released; press fires on the edge that accepts a low level.
    always_comb begin
        deb_cnt_d   = deb_cnt_q;
        deb_level_d = deb_level_q;
        if (sync2_q != deb_level_q) begin
            if (deb_cnt_q == DebLast) begin
                deb_level_d = sync2_q;
                deb_cnt_d   = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end else begin
            deb_cnt_d = '0;
        end
        press = deb_level_q & ~deb_level_d;
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        step_d     = 1'b0;
        in_data_d  = in_data_q;
        out_data_d = out_data_q;
        case (state_q)
            StRun: begin
                if (io.halt) begin
                    state_d = StHalted;
                end else if (io.is_in) begin
                    state_d = StWaitIn;
                end else if (io.is_out) begin
                    out_data_d = io.out_value;
                    state_d    = StWaitOut;
`ifdef SINGLE_STEP_EN
                end else if (io.step_sw) begin
                    if (press) begin
                        step_d  = 1'b1;
                        state_d = StRelease;
                    end
`endif
                end else if (!io.congela_sw) begin
                    if (div_q == DivLast) begin
                        div_d  = '0;
                        step_d = 1'b1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            StWaitIn: begin
                if (press) begin
                    in_data_d = io.switches;
                    step_d    = 1'b1;
                    state_d   = StRelease;
                end
            end
            StWaitOut: begin
                if (press) begin
                    step_d  = 1'b1;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                // Waiting for release keeps one physical press from clearing two wait states.
                if (deb_level_d) begin
                    state_d = StRun;
                    div_d   = '0;
                end
            end
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
        led_d    = led_q ^ step_d;
        cin_d    = (state_d == StWaitIn);
        cout_d   = (state_d == StWaitOut);
        halted_d = (state_d == StHalted);
    end

    always_ff @(posedge clock_fpga or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            deb_cnt_q   <= '0;
            deb_level_q <= 1'b1;
            state_q     <= StRun;
            div_q       <= '0;
            step_q      <= 1'b0;
            led_q       <= 1'b0;
            cin_q       <= 1'b0;
            cout_q      <= 1'b0;
            halted_q    <= 1'b0;
            in_data_q   <= '0;
            out_data_q  <= '0;
        end else begin
            sync1_q     <= io.botao;
            sync2_q     <= sync1_q;
            deb_cnt_q   <= deb_cnt_d;
            deb_level_q <= deb_level_d;
            state_q     <= state_d;
            div_q       <= div_d;
            step_q      <= step_d;
            led_q       <= led_d;
            cin_q       <= cin_d;
            cout_q      <= cout_d;
            halted_q    <= halted_d;
            in_data_q   <= in_data_d;
            out_data_q  <= out_data_d;
        end
    end

    assign io.step_en     = step_q;
    assign io.congela_in  = cin_q;
    assign io.congela_out = cout_q;
    assign io.halted      = halted_q;
    assign io.in_data     = in_data_q;
    assign io.out_data    = out_data_q;
    assign io.led_pc      = led_q;
    assign io.state       = state_q;

endmodule

// File: tb/tb_io_step_controller.sv
// Self-checking bench for io_step_controller with DIV_COUNT=4, DEB_CYCLES=3.
module tb_io_step_controller;

    localparam int unsigned Div = 4;
    localparam int unsigned Deb = 3;
    localparam int unsigned Dw  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    io_step_if #(.DATA_WIDTH(Dw)) bus ();

    io_step_controller #(
        .DIV_COUNT (Div),
        .DEB_CYCLES(Deb),
        .DATA_WIDTH(Dw)
    ) dut (
        .clock_fpga(clk),
        .reset_n   (rst_n),
        .io        (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       is_in;
        logic       is_out;
        logic       halt;
        logic [2:0] st;
        logic       ci;
        logic       co;
        logic       h;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks n cycles, counting step pulses; the core leaves IN/OUT once it has stepped.
    task automatic run(input int n, output int steps);
        steps = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.step_en === 1'b1) begin
                steps++;
                bus.is_in  = 1'b0;
                bus.is_out = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        bus.botao      = 1'b1;
        bus.congela_sw = 1'b0;
        bus.switches   = 8'h00;
        bus.is_in      = 1'b0;
        bus.is_out     = 1'b0;
        bus.halt       = 1'b0;
        bus.out_value  = '0;
`ifdef SINGLE_STEP_EN
        bus.step_sw    = 1'b0;
`endif
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int          steps;
    int          en;
    logic        exp_step;
    logic        exp_led;
    logic [7:0]  exp_in;
    logic [31:0] exp_out;
    logic [31:0] v;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1};

        do_reset();
        check("reset_outputs",
              {bus.step_en, bus.congela_in, bus.congela_out, bus.halted, bus.in_data,
               bus.out_data, bus.led_pc, bus.state}, 64'd0);

        // Priority decode from RUN
        for (int i = 0; i < 8; i++) begin
            do_reset();
            bus.is_in  = vecs[i].is_in;
            bus.is_out = vecs[i].is_out;
            bus.halt   = vecs[i].halt;
            tick();
            check("priority",
                  {bus.state, bus.congela_in, bus.congela_out, bus.halted, bus.step_en},
                  {vecs[i].st, vecs[i].ci, vecs[i].co, vecs[i].h, 1'b0});
        end

        // Free-running divider with random freeze: every 4th enabled cycle steps
        do_reset();
        en = 0;
        exp_led = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bus.congela_sw = ($urandom_range(0, 3) == 0);
            tick();
            exp_step = 1'b0;
            if (!bus.congela_sw) begin
                en++;
                exp_step = (en % Div == 0);
            end
            exp_led ^= exp_step;
            check("rand_step", bus.step_en, exp_step);
        end
        check("rand_led", bus.led_pc, exp_led);
        bus.congela_sw = 1'b0;

        // IN with held press
        do_reset();
        bus.is_in    = 1'b1;
        bus.switches = 8'hA5;
        tick();
        check("in_wait", {bus.congela_in, bus.state}, {1'b1, 3'd1});
        bus.botao = 1'b0;
        run(4, steps);
        check("in_latency_early", {steps[7:0], bus.congela_in}, {8'd0, 1'b1});
        tick();
        check("in_latency_step", bus.step_en, 1'b1);
        bus.is_in = 1'b0;
        run(5, steps);
        check("in_single_step", steps, 0);
        check("in_capture", {bus.in_data, bus.state, bus.congela_in}, {8'hA5, 3'd3, 1'b0});
        bus.botao = 1'b1;
        run(4, steps);
        check("in_release_hold", bus.state, 3'd3);
        tick();
        check("in_release_run", bus.state, 3'd0);

        // OUT: value captured on entry and held while the source changes
        do_reset();
        bus.out_value = 32'd1234;
        bus.is_out    = 1'b1;
        tick();
        bus.out_value = 32'd0;
        run(3, steps);
        check("out_hold", {bus.out_data, bus.congela_out, bus.state}, {32'd1234, 1'b1, 3'd2});
        bus.botao = 1'b0;
        run(10, steps);
        check("out_one_step", steps, 1);
        check("out_after", {bus.out_data, bus.congela_out}, {32'd1234, 1'b0});
        bus.botao = 1'b1;
        run(6, steps);

        // Bounce in WAIT_IN is rejected, then a stable press is accepted
        do_reset();
        bus.is_in = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            bus.botao = logic'(i % 2);
            run(1, steps);
            check("bounce_no_step", steps, 0);
        end
        bus.botao = 1'b1;
        run(4, steps);
        check("bounce_settle", {steps[7:0], bus.congela_in}, {8'd0, 1'b1});
        bus.botao = 1'b0;
        run(5, steps);
        check("bounce_stable_press", steps, 1);
        bus.botao = 1'b1;
        run(6, steps);

        // Freeze holds the divider mid-count
        do_reset();
        run(2, steps);
        bus.congela_sw = 1'b1;
        run(20, steps);
        check("freeze_no_step", steps, 0);
        bus.congela_sw = 1'b0;
        tick();
        check("freeze_resume_1", bus.step_en, 1'b0);
        tick();
        check("freeze_resume_2", bus.step_en, 1'b1);

        // HALT wins over IN and ignores presses
        do_reset();
        bus.halt  = 1'b1;
        bus.is_in = 1'b1;
        tick();
        check("halt_enter", {bus.state, bus.halted, bus.congela_in}, {3'd4, 1'b1, 1'b0});
        en = 0;
        for (int i = 0; i < 5; i++) begin
            bus.botao = 1'b0;
            run(10, steps);
            en += steps;
            bus.botao = 1'b1;
            run(10, steps);
            en += steps;
        end
        check("halt_no_step", en, 0);
        check("halt_stays", {bus.state, bus.halted}, {3'd4, 1'b1});

        // Random IN/OUT transactions against latched-value model
        do_reset();
        exp_in  = 8'h00;
        exp_out = 32'h0;
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                bus.switches = ~v[7:0];
                bus.is_in    = 1'b1;
                tick();
                check("rt_in_state", bus.state, 3'd1);
                bus.switches = v[7:0];
                exp_in       = v[7:0];
            end else begin
                bus.out_value = v;
                bus.is_out    = 1'b1;
                tick();
                check("rt_out_state", bus.state, 3'd2);
                bus.out_value = ~v;
                exp_out       = v;
            end
            bus.botao = 1'b0;
            run(8, steps);
            check("rt_steps", steps, 1);
            check("rt_latches", {bus.in_data, bus.out_data}, {exp_in, exp_out});
            bus.botao = 1'b1;
            run(5, steps);
            check("rt_back_run", bus.state, 3'd0);
        end

        // Async reset mid-wait clears latches without a step
        do_reset();
        bus.out_value = 32'hCAFE;
        run(5, steps);
        bus.is_out = 1'b1;
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset",
              {bus.step_en, bus.congela_in, bus.congela_out, bus.halted, bus.in_data,
               bus.out_data, bus.led_pc, bus.state}, 64'd0);
        bus.is_out = 1'b0;
        tick();
        check("reset_held_no_step", bus.step_en, 1'b0);
        rst_n = 1'b1;
        exp_led = 1'b0;
        for (int t = 1; t <= 16; t++) begin
            tick();
            exp_step = (t % Div == 0);
            exp_led ^= exp_step;
            check("post_reset_run", {bus.step_en, bus.led_pc}, {exp_step, exp_led});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
